iddr_align_ctrl: RTL and testbench

- Receive-side responder to the IDDR init sequencer; consumes its synrst / update / alignwd controls and returns the ready handshake.
- Performs word alignment on the deserialized parallel word: compares it against a training pattern, issues bitslip pulses to the IDDR primitive until lock, then asserts ready.
- Sits between the IDDR init sequencer and the IDDR gearbox, in the same clock domain as the parallel data.

---
 rtl/iddr_align_pkg.sv | 20 ++
 rtl/iddr_align_ctrl.sv | 119 +++++++++++
 tb/tb_iddr_align_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iddr_align_pkg.sv
// Shared constants and state encoding for the IDDR receive-side word aligner.
package iddr_align_pkg;

  localparam int unsigned SLIP_CNT_W = 8;

  localparam logic [7:0]  TRAIN_PAT_DEF  = 8'h5C;
  localparam int unsigned SETTLE_CYC_DEF = 16;
  localparam int unsigned MATCH_CNT_DEF  = 4;
  localparam int unsigned MAX_SLIP_DEF   = 16;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSettle = 3'd1;
  localparam state_t StCheck  = 3'd2;
  localparam state_t StSlip   = 3'd3;
  localparam state_t StLocked = 3'd4;
  localparam state_t StFail   = 3'd5;

endpackage

// File: rtl/iddr_align_ctrl.sv
// Word aligner answering the IDDR init sequencer: bitslips until the training
// pattern is seen MATCH_CNT times in a row, then returns ready.
module iddr_align_ctrl
  import iddr_align_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter logic [DATA_W-1:0] TRAIN_PAT  = DATA_W'(TRAIN_PAT_DEF),
  parameter int unsigned       SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned       MATCH_CNT  = MATCH_CNT_DEF,
  parameter int unsigned       MAX_SLIP   = MAX_SLIP_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_iddr_synrst,
  input  logic                  i_iddr_update,
  input  logic                  i_iddr_alignwd,
  input  logic [DATA_W-1:0]     i_rx_data,
  output logic                  o_bitslip,
  output logic                  o_iddr_ready,
  output logic                  o_align_err,
  output logic [SLIP_CNT_W-1:0] o_slip_cnt
);

  localparam logic [7:0]            SettleLoad = 8'(SETTLE_CYC - 1);
  localparam logic [3:0]            MatchLast  = 4'(MATCH_CNT - 1);
  localparam logic [SLIP_CNT_W-1:0] SlipLimit  = SLIP_CNT_W'(MAX_SLIP);

  state_t                  state_q, state_d;
  logic [7:0]              settle_q, settle_d;
  logic [3:0]              match_q, match_d;
  logic [SLIP_CNT_W-1:0]   slip_q, slip_d;
  logic                    ready_q, ready_d;
  logic                    update_d1;
  logic                    start;
  logic                    hit;

  assign start = i_iddr_update & ~update_d1 & ~i_iddr_synrst;
  assign hit   = (i_rx_data == TRAIN_PAT);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
    // Ready lags the LOCKED state by one cycle.
    ready_d  = (state_q == StLocked);
    if (i_iddr_synrst) begin
      state_d  = StIdle;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
      ready_d  = 1'b0;
    end else if (start) begin
      slip_d  = '0;
      match_d = '0;
      ready_d = 1'b0;
      if (i_iddr_alignwd) begin
        state_d  = StSettle;
        settle_d = SettleLoad;
      end else begin
        state_d = StLocked;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StSettle: begin
          if (settle_q == '0) begin
            state_d = StCheck;
            match_d = '0;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        StCheck: begin
          if (hit) begin
            if (match_q == MatchLast) state_d = StLocked;
            else                      match_d = match_q + 4'd1;
          end else begin
            match_d = '0;
            state_d = (slip_q >= SlipLimit) ? StFail : StSlip;
          end
        end
        StSlip: begin
          if (slip_q != '1) slip_d = slip_q + 1'b1;
          settle_d = SettleLoad;
          state_d  = StSettle;
        end
        StLocked: ;
        StFail:   ;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      ready_q   <= 1'b0;
      update_d1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      ready_q   <= ready_d;
      update_d1 <= i_iddr_update;
    end
  end

  // A restart landing on the SLIP cycle suppresses that pulse.
  assign o_bitslip    = (state_q == StSlip) & ~start;
  assign o_iddr_ready = ready_q;
  assign o_align_err  = (state_q == StFail);
  assign o_slip_cnt   = slip_q;

endmodule

// File: tb/tb_iddr_align_ctrl.sv
// Directed bench for iddr_align_ctrl: table of alignment scenarios plus
// hand-written sequences for failure, partial match, synrst and async reset.
module tb_iddr_align_ctrl;
  import iddr_align_pkg::*;

  localparam logic [7:0] PAT = 8'h5C;

  logic       clk = 1'b0;
  logic       rst;
  logic       synrst;
  logic       update;
  logic       alignwd;
  logic [7:0] rx_data;
  logic       bitslip;
  logic       ready;
  logic       err;
  logic [7:0] slip_cnt;

  logic       use_model = 1'b0;
  logic [2:0] off_init  = 3'd0;
  logic [7:0] rx_fixed  = 8'h00;
  logic       mon_clr   = 1'b1;

  logic [2:0] offset     = 3'd0;
  int         cyc        = 0;
  int         mon_slips  = 0;
  int         mon_last   = 0;
  int         mon_gap    = 0;
  int         mon_consec = 0;
  logic       prev_bs    = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  iddr_align_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_iddr_synrst  (synrst),
    .i_iddr_update  (update),
    .i_iddr_alignwd (alignwd),
    .i_rx_data      (rx_data),
    .o_bitslip      (bitslip),
    .o_iddr_ready   (ready),
    .o_align_err    (err),
    .o_slip_cnt     (slip_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] p, input logic [2:0] k);
    return (p << k) | (p >> (4'd8 - {1'b0, k}));
  endfunction

  // Channel model: each bitslip moves the received word one bit closer to aligned.
  assign rx_data = use_model ? rotl(PAT, offset) : rx_fixed;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_bs <= bitslip;
    if (mon_clr) begin
      offset     <= off_init;
      mon_slips  <= 0;
      mon_gap    <= 0;
      mon_consec <= 0;
    end else if (bitslip) begin
      offset    <= offset - 3'd1;
      mon_slips <= mon_slips + 1;
      mon_last  <= cyc;
      if (mon_slips > 0 && (mon_gap == 0 || cyc - mon_last < mon_gap)) mon_gap <= cyc - mon_last;
      if (prev_bs) mon_consec <= 1;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic prep(input logic model, input logic [2:0] off, input logic [7:0] fixed);
    @(negedge clk);
    synrst    = 1'b1;
    update    = 1'b0;
    alignwd   = 1'b0;
    use_model = model;
    off_init  = off;
    rx_fixed  = fixed;
    mon_clr   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    synrst  = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic start(input logic wd);
    @(negedge clk);
    update  = 1'b1;
    alignwd = wd;
  endtask

  // Latency counted in clock edges after the edge that sees the update rise.
  task automatic wait_ready(output int lat);
    lat = 0;
    @(negedge clk);
    while (!ready && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!ready) lat = -1;
  endtask

  typedef struct {
    logic       wd;
    logic [2:0] off;
    int         lat;
    int         slips;
    int         gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int n;

    vecs[0] = '{wd: 1'b1, off: 3'd0, lat: 21,  slips: 0, gap: 0};
    vecs[1] = '{wd: 1'b1, off: 3'd3, lat: 75,  slips: 3, gap: 18};
    vecs[2] = '{wd: 1'b1, off: 3'd1, lat: 39,  slips: 1, gap: 0};
    vecs[3] = '{wd: 1'b1, off: 3'd5, lat: 111, slips: 5, gap: 18};
    vecs[4] = '{wd: 1'b0, off: 3'd3, lat: 1,   slips: 0, gap: 0};

    rst     = 1'b1;
    synrst  = 1'b1;
    update  = 1'b0;
    alignwd = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", int'(ready), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_bitslip", int'(bitslip), 0);
    chk("reset_slip_cnt", int'(slip_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      prep(1'b1, vecs[i].off, 8'h00);
      start(vecs[i].wd);
      wait_ready(lat);
      if (i == 0) $display("aligned lock latency: ready seen %0d edges after start edge", lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_bitslips", i), mon_slips, vecs[i].slips);
      chk($sformatf("vec%0d_slip_cnt", i), int'(slip_cnt), vecs[i].slips);
      chk($sformatf("vec%0d_err", i), int'(err), 0);
      chk($sformatf("vec%0d_min_gap", i), mon_gap, vecs[i].gap);
      chk($sformatf("vec%0d_consec", i), mon_consec, 0);
    end

    // Update falling while locked keeps ready; async reset drops it at once.
    @(negedge clk);
    update = 1'b0;
    repeat (3) @(negedge clk);
    chk("locked_hold_ready", int'(ready), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", int'(ready), 0);
    chk("async_rst_slip_cnt", int'(slip_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Never-matching data runs out of slips, then a fresh start recovers.
    prep(1'b0, 3'd0, 8'h00);
    start(1'b1);
    n = 0;
    @(negedge clk);
    while (!err && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("fail_latency", n, 305);
    chk("fail_err", int'(err), 1);
    chk("fail_ready", int'(ready), 0);
    chk("fail_bitslips", mon_slips, 16);
    chk("fail_slip_cnt", int'(slip_cnt), 16);
    @(negedge clk);
    update   = 1'b0;
    rx_fixed = PAT;
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    chk("retry_err_cleared", int'(err), 0);
    chk("retry_slip_cnt", int'(slip_cnt), 0);
    n = 0;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("retry_latency", n, 21);

    // Three matches then a mismatch: one slip, then four fresh matches needed.
    prep(1'b0, 3'd0, PAT);
    start(1'b1);
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      if (n == 19) rx_fixed = 8'h00;
      if (n == 20) rx_fixed = PAT;
      @(negedge clk);
      n++;
    end
    chk("partial_latency", n, 42);
    chk("partial_bitslips", mon_slips, 1);
    chk("partial_slip_cnt", int'(slip_cnt), 1);

    // synrst during SETTLE after two slips.
    prep(1'b1, 3'd3, 8'h00);
    start(1'b1);
    n = 0;
    while (mon_slips < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("synrst_pre_slips", mon_slips, 2);
    repeat (4) @(negedge clk);
    chk("synrst_pre_slip_cnt", int'(slip_cnt), 2);
    synrst = 1'b1;
    @(negedge clk);
    chk("synrst_slip_cnt", int'(slip_cnt), 0);
    chk("synrst_ready", int'(ready), 0);
    chk("synrst_err", int'(err), 0);
    chk("synrst_bitslip", int'(bitslip), 0);
    chk("synrst_state", int'(dut.state_q), int'(StIdle));
    @(negedge clk);
    synrst = 1'b0;
    update = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
